// File: rtl/trap_controller_pkg.sv
// Shared CSR addresses, privilege and cause encodings, FSM states and mstatus/target helpers
// for the machine-mode trap controller; purely combinational, no handshakes.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TRAP_RD  = 3'd1,
    S_TRAP_WR  = 3'd2,
    S_RET_RD   = 3'd3,
    S_RET_WR   = 3'd4,
    S_REDIRECT = 3'd5
  } state_t;

  // Everything captured at accept time; mcause[31] doubles as the interrupt flag.
  typedef struct packed {
    logic [31:0] mcause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] mstatus;
  } trap_ctx_t;

  // Modes 2 and 3 of mtvec fall back to direct; vectoring applies to interrupts only.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] mcause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && mcause[31])
      return base + {25'b0, mcause[4:0], 2'b00};
    return base;
  endfunction

  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms, input logic [1:0] cur_mode);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[12:11]        = cur_mode;
    return r;
  endfunction

  function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[12:11]        = MODE_U;
    return r;
  endfunction

endpackage

// File: rtl/trap_controller_irq_arbiter.sv
// Machine interrupt arbiter: pending flag and winning cause code (MEI > MSI > MTI).
// Purely combinational, zero latency; no backpressure.
module irq_arbiter
  import trap_controller_pkg::*;
(
  input  logic [2:0]  irq_lines,
  input  logic [31:0] mie,
  input  logic [31:0] mstatus,
  input  logic [1:0]  mode,
  output logic        pending,
  output logic [4:0]  code
);

  logic [2:0] enabled;
  logic       global_en;
  logic       unused_bits;

  assign unused_bits = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0],
                         mstatus[31:4], mstatus[2:0]};

  always_comb begin
    // irq_lines is {meip, mtip, msip}, matching mie bits {11, 7, 3}
    enabled   = irq_lines & {mie[11], mie[7], mie[3]};
    global_en = (mode != MODE_M) || mstatus[MSTATUS_MIE];
    pending   = global_en && (enabled != 3'b000);
    code      = 5'd0;
    if (enabled[2])
      code = IRQ_MEI;
    else if (enabled[0])
      code = IRQ_MSI;
    else if (enabled[1])
      code = IRQ_MTI;
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap/MRET sequencer over a 5-slot implicit CSR port; redirect 3 cycles after accept.
// Holds busy/flush from accept through redirect; requests arriving while busy are dropped, not queued.
module trap_controller
  import trap_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_valid,
  input  logic [4:0]   exc_cause,
  input  logic [31:0]  exc_epc,
  input  logic [31:0]  exc_tval,
  input  logic         mret,
  input  logic [2:0]   irq_lines,
  output logic [59:0]  impl_addrs_r,
  output logic [4:0]   impl_read_enable,
  input  logic [159:0] impl_csr,
  output logic [59:0]  impl_addrs_w,
  output logic [4:0]   impl_write_enable,
  output logic [159:0] impl_write_data,
  output logic         busy,
  output logic         flush,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic [1:0]   mode
);

  state_t      state;
  trap_ctx_t   ctx;
  logic [31:0] target_q;
  logic [31:0] csr0;
  logic [31:0] csr1;
  logic        irq_pending;
  logic [4:0]  irq_code;
  logic        take_exc;
  logic        take_irq;
  logic        take_ret;
  logic        accept;
  logic        unused_csr;

  assign csr0       = impl_csr[31:0];
  assign csr1       = impl_csr[63:32];
  assign unused_csr = ^impl_csr[159:64];

  // In IDLE slots 0/1 carry mstatus/mie, which is all the arbiter needs.
  irq_arbiter u_irq_arbiter (
    .irq_lines (irq_lines),
    .mie       (csr1),
    .mstatus   (csr0),
    .mode      (mode),
    .pending   (irq_pending),
    .code      (irq_code)
  );

  always_comb begin
    take_exc = 1'b0;
    take_irq = 1'b0;
    take_ret = 1'b0;
    if (!reset && state == S_IDLE) begin
      if (exc_valid)
        take_exc = 1'b1;
      else if (irq_pending)
        take_irq = 1'b1;
      else if (mret)
        take_ret = 1'b1;
    end
    accept = take_exc || take_irq || take_ret;
  end

  assign busy  = !reset && ((state != S_IDLE) || accept);
  assign flush = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mode           <= MODE_M;
      ctx            <= '0;
      target_q       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take_exc) begin
            ctx   <= '{mcause: {27'b0, exc_cause}, epc: exc_epc, tval: exc_tval, mstatus: csr0};
            state <= S_TRAP_RD;
          end else if (take_irq) begin
            ctx   <= '{mcause: {1'b1, 26'b0, irq_code}, epc: exc_epc, tval: 32'h0, mstatus: csr0};
            state <= S_TRAP_RD;
          end else if (take_ret) begin
            ctx.mstatus <= csr0;
            state       <= S_RET_RD;
          end
        end
        S_TRAP_RD: begin
          target_q <= trap_target(csr0, ctx.mcause);
          state    <= S_TRAP_WR;
        end
        S_TRAP_WR: begin
          mode           <= MODE_M;
          redirect_valid <= 1'b1;
          redirect_pc    <= target_q;
          state          <= S_REDIRECT;
        end
        S_RET_RD: begin
          target_q <= {csr0[31:2], 2'b00};
          state    <= S_RET_WR;
        end
        S_RET_WR: begin
          mode           <= ctx.mstatus[12:11];
          redirect_valid <= 1'b1;
          redirect_pc    <= target_q;
          state          <= S_REDIRECT;
        end
        S_REDIRECT: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // CSR port is a pure decode of registered state; reset masks it so an aborted
  // sequence cannot issue another write.
  always_comb begin
    impl_addrs_r      = '0;
    impl_read_enable  = '0;
    impl_addrs_w      = '0;
    impl_write_enable = '0;
    impl_write_data   = '0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          impl_addrs_r[11:0]  = CSR_MSTATUS;
          impl_addrs_r[23:12] = CSR_MIE;
          impl_read_enable    = 5'b00011;
        end
        S_TRAP_RD: begin
          impl_addrs_r[11:0] = CSR_MTVEC;
          impl_read_enable   = 5'b00001;
        end
        S_TRAP_WR: begin
          impl_addrs_w[11:0]      = CSR_MEPC;
          impl_addrs_w[23:12]     = CSR_MCAUSE;
          impl_addrs_w[35:24]     = CSR_MTVAL;
          impl_addrs_w[47:36]     = CSR_MSTATUS;
          impl_write_data[31:0]   = {ctx.epc[31:2], 2'b00};
          impl_write_data[63:32]  = ctx.mcause;
          impl_write_data[95:64]  = ctx.tval;
          impl_write_data[127:96] = trap_mstatus(ctx.mstatus, mode);
          impl_write_enable       = 5'b01111;
        end
        S_RET_RD: begin
          impl_addrs_r[11:0] = CSR_MEPC;
          impl_read_enable   = 5'b00001;
        end
        S_RET_WR: begin
          impl_addrs_w[11:0]    = CSR_MSTATUS;
          impl_write_data[31:0] = ret_mstatus(ctx.mstatus);
          impl_write_enable     = 5'b00001;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a tiny CSR read model plus hand-computed
// expectations for traps, interrupts, MRET, masking and mid-sequence reset.
module tb_trap_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         exc_valid;
  logic [4:0]   exc_cause;
  logic [31:0]  exc_epc;
  logic [31:0]  exc_tval;
  logic         mret;
  logic [2:0]   irq_lines;
  logic [59:0]  impl_addrs_r;
  logic [4:0]   impl_read_enable;
  logic [159:0] impl_csr;
  logic [59:0]  impl_addrs_w;
  logic [4:0]   impl_write_enable;
  logic [159:0] impl_write_data;
  logic         busy;
  logic         flush;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [1:0]   mode;

  logic [31:0] m_mstatus;
  logic [31:0] m_mie;
  logic [31:0] m_mtvec;
  logic [31:0] m_mepc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk               (clk),
    .reset             (reset),
    .exc_valid         (exc_valid),
    .exc_cause         (exc_cause),
    .exc_epc           (exc_epc),
    .exc_tval          (exc_tval),
    .mret              (mret),
    .irq_lines         (irq_lines),
    .impl_addrs_r      (impl_addrs_r),
    .impl_read_enable  (impl_read_enable),
    .impl_csr          (impl_csr),
    .impl_addrs_w      (impl_addrs_w),
    .impl_write_enable (impl_write_enable),
    .impl_write_data   (impl_write_data),
    .busy              (busy),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .mode              (mode)
  );

  always_comb begin
    impl_csr = '0;
    for (int i = 0; i < 5; i++) begin
      case (impl_addrs_r[12*i +: 12])
        12'h300: impl_csr[32*i +: 32] = m_mstatus;
        12'h304: impl_csr[32*i +: 32] = m_mie;
        12'h305: impl_csr[32*i +: 32] = m_mtvec;
        12'h341: impl_csr[32*i +: 32] = m_mepc;
        default: impl_csr[32*i +: 32] = 32'h0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_valid = 1'b0;
    exc_cause = 5'd0;
    exc_epc   = 32'h0;
    exc_tval  = 32'h0;
    mret      = 1'b0;
    irq_lines = 3'b000;
  endtask

  // Caller applies the request at a negedge (cycle N); mret is pulsed while busy to show it is dropped.
  task automatic do_trap(input string tag, input logic [31:0] w_epc, input logic [31:0] w_cause,
                         input logic [31:0] w_tval, input logic [31:0] w_mstatus,
                         input logic [31:0] target);
    #1;
    check({tag, ".busy_accept"}, busy, 1);
    check({tag, ".flush_accept"}, flush, 1);
    @(negedge clk);
    clear_inputs();
    mret = 1'b1;
    #1;
    check({tag, ".rd_en"}, impl_read_enable, 5'b00001);
    check({tag, ".rd_addr"}, impl_addrs_r[11:0], 12'h305);
    check({tag, ".no_wr_rd"}, impl_write_enable, 0);
    @(negedge clk);
    #1;
    check({tag, ".wr_en"}, impl_write_enable, 5'b01111);
    check({tag, ".wr_addr"}, impl_addrs_w[47:0], 48'h300343342341);
    check({tag, ".mepc"}, impl_write_data[31:0], w_epc);
    check({tag, ".mcause"}, impl_write_data[63:32], w_cause);
    check({tag, ".mtval"}, impl_write_data[95:64], w_tval);
    check({tag, ".mstatus"}, impl_write_data[127:96], w_mstatus);
    check({tag, ".rv_early"}, redirect_valid, 0);
    @(negedge clk);
    #1;
    check({tag, ".rv"}, redirect_valid, 1);
    check({tag, ".pc"}, redirect_pc, target);
    check({tag, ".mode"}, mode, 2'b11);
    check({tag, ".busy_redir"}, busy, 1);
    @(negedge clk);
    mret = 1'b0;
    #1;
    check({tag, ".rv_off"}, redirect_valid, 0);
    check({tag, ".pc_hold"}, redirect_pc, target);
    check({tag, ".busy_off"}, busy, 0);
  endtask

  task automatic do_ret(input string tag, input logic [31:0] w_mstatus, input logic [1:0] new_mode,
                        input logic [31:0] target);
    mret = 1'b1;
    #1;
    check({tag, ".busy_accept"}, busy, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    check({tag, ".rd_en"}, impl_read_enable, 5'b00001);
    check({tag, ".rd_addr"}, impl_addrs_r[11:0], 12'h341);
    @(negedge clk);
    #1;
    check({tag, ".wr_en"}, impl_write_enable, 5'b00001);
    check({tag, ".wr_addr"}, impl_addrs_w[11:0], 12'h300);
    check({tag, ".mstatus"}, impl_write_data[31:0], w_mstatus);
    @(negedge clk);
    #1;
    check({tag, ".rv"}, redirect_valid, 1);
    check({tag, ".pc"}, redirect_pc, target);
    check({tag, ".mode"}, mode, new_mode);
    @(negedge clk);
    #1;
    check({tag, ".rv_off"}, redirect_valid, 0);
    check({tag, ".busy_off"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_mstatus = 32'h8;
    m_mie     = 32'h0;
    m_mtvec   = 32'h8000;
    m_mepc    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst.rd_en", impl_read_enable, 0);
    check("rst.wr_en", impl_write_enable, 0);
    check("rst.mode", mode, 2'b11);
    check("rst.busy", busy, 0);
    check("rst.rv", redirect_valid, 0);
    check("rst.pc", redirect_pc, 0);
    reset = 1'b0;
    #1;
    check("idle.rd_en", impl_read_enable, 5'b00011);
    check("idle.rd_addr", impl_addrs_r[23:0], 24'h304300);

    // Synchronous exception, direct mtvec
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd2; exc_epc = 32'h100; exc_tval = 32'hDEAD;
    do_trap("exc", 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h8000);

    // Vectored timer interrupt: tval forced to 0, epc from exc_epc
    m_mtvec = 32'h8001; m_mie = 32'h80; m_mstatus = 32'h8;
    @(negedge clk);
    irq_lines = 3'b010; exc_epc = 32'h444; exc_tval = 32'h55;
    do_trap("mti", 32'h444, 32'h80000007, 32'h0, 32'h1880, 32'h801C);

    m_mie = 32'h888;
    @(negedge clk);
    irq_lines = 3'b111; exc_epc = 32'h500; exc_tval = 32'h99;
    do_trap("mei", 32'h500, 32'h8000000B, 32'h0, 32'h1880, 32'h802C);

    @(negedge clk);
    irq_lines = 3'b011; exc_epc = 32'h504;
    do_trap("msi", 32'h504, 32'h80000003, 32'h0, 32'h1880, 32'h800C);

    // Exception beats simultaneous interrupts; vectored mode still uses base
    @(negedge clk);
    irq_lines = 3'b111; exc_valid = 1'b1; exc_cause = 5'd5; exc_epc = 32'h602; exc_tval = 32'h77;
    do_trap("exc_wins", 32'h600, 32'h5, 32'h77, 32'h1880, 32'h8000);

    // M-mode with MIE clear: interrupt must be masked
    m_mstatus = 32'h0; m_mie = 32'h80;
    @(negedge clk);
    irq_lines = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("masked.busy", busy, 0);
      check("masked.wr_en", impl_write_enable, 0);
      @(negedge clk);
    end
    irq_lines = 3'b000;

    m_mstatus = 32'h80; m_mepc = 32'h2002;
    do_ret("mret", 32'h88, 2'b00, 32'h2000);

    // U-mode ignores MIE, so the same interrupt is now taken
    m_mstatus = 32'h0; m_mie = 32'h80; m_mtvec = 32'h102;
    @(negedge clk);
    irq_lines = 3'b010; exc_epc = 32'h3006;
    do_trap("umode_irq", 32'h3004, 32'h80000007, 32'h0, 32'h0, 32'h100);

    m_mstatus = 32'h0;
    do_ret("mret2", 32'h80, 2'b00, 32'h2000);

    // Reset lands while the trap is in TRAP_RD
    m_mtvec = 32'h200;
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd8; exc_epc = 32'h700;
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    check("abort.wr_en_rst", impl_write_enable, 0);
    @(negedge clk);
    check("abort.mode", mode, 2'b11);
    check("abort.busy", busy, 0);
    check("abort.pc", redirect_pc, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("abort.wr_en", impl_write_enable, 0);
      check("abort.rv", redirect_valid, 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
